// File: rtl/prng_xoshiro_axis_if.sv
// AXI-stream beat channel carrying packed random words.
interface prng_xoshiro_axis_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/prng_xoshiro_axis.sv
// xoshiro128** generator with serial MT-style seeding,
// word packing and a FWFT output FIFO on AXI-stream.
module prng_xoshiro_axis #(
  parameter int          OUT_WORDS    = 1,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] DEFAULT_SEED = 32'd5489
) (
  input  logic                        clk,
  input  logic                        rst,
  prng_xoshiro_axis_if.master         output_axis,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  input  logic [31:0]                 seed_val,
  input  logic                        seed_start
);

  localparam int DW = 32 * OUT_WORDS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (OUT_WORDS > 1) ?
                      $clog2(OUT_WORDS) : 1;
  localparam logic [31:0] MULT = 32'd1812433253;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(OUT_WORDS-1);

  typedef enum logic [1:0] {
    SEED_INIT,
    SEED_MUL,
    SEED_WR,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [31:0]    seed_q, a_q, acc_q, wr_x;
  logic [4:0]     mul_cnt_q;
  logic [2:0]     i_q;
  logic [31:0]    s_q [4];
  logic [31:0]    sn  [4];
  logic [31:0]    x0, x1, x2, x3, t;
  logic [31:0]    m5, word;
  logic [DW-1:0]  pack_q, beat_w, beat_q;
  logic           beat_v_q;
  logic [PW-1:0]  pack_cnt_q;
  logic [DW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    lvl_q;
  logic           pop, push, full, adv, last;

  function automatic logic [31:0] rotl(
    input logic [31:0] x,
    input int unsigned k
  );
    return (x << k) | (x >> (32 - k));
  endfunction

  assign t  = s_q[1] << 9;
  assign x2 = s_q[2] ^ s_q[0];
  assign x3 = s_q[3] ^ s_q[1];
  assign x1 = s_q[1] ^ x2;
  assign x0 = s_q[0] ^ x3;
  assign sn[0] = x0;
  assign sn[1] = x1;
  assign sn[2] = x2 ^ t;
  assign sn[3] = rotl(x3, 11);

  assign m5   = s_q[1] * 32'd5;
  assign word = rotl(m5, 7) * 32'd9;
  assign wr_x = acc_q + {29'd0, i_q};

  always_comb begin
    beat_w = pack_q;
    for (int k = 0; k < OUT_WORDS; k++) begin
      if (pack_cnt_q == PW'(k)) begin
        beat_w[32*k +: 32] = word;
      end
    end
  end

  assign output_axis.tvalid = (lvl_q != '0);
  assign output_axis.tdata  = output_axis.tvalid ?
                              mem[rd_ptr_q] : '0;
  assign fifo_level = lvl_q;
  assign busy = (state_q != RUN) && !rst;

  // A finished beat waits in beat_q for one FIFO write slot.
  assign pop  = output_axis.tvalid && output_axis.tready;
  assign full = (lvl_q == FULL);
  assign push = beat_v_q && (!full || pop);
  assign adv  = (state_q == RUN) && (!beat_v_q || push);
  assign last = (pack_cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEED_INIT: state_d = SEED_MUL;
      SEED_MUL:
        if (mul_cnt_q == 5'd0) state_d = SEED_WR;
      SEED_WR:
        state_d = (i_q == 3'd4) ? RUN : SEED_MUL;
      RUN: state_d = RUN;
      default: state_d = SEED_INIT;
    endcase
    if (seed_start) state_d = SEED_INIT;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED_INIT;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= beat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q     <= DEFAULT_SEED;
      a_q        <= '0;
      acc_q      <= '0;
      mul_cnt_q  <= '0;
      i_q        <= '0;
      for (int k = 0; k < 4; k++) s_q[k] <= '0;
      pack_q     <= '0;
      beat_q     <= '0;
      beat_v_q   <= 1'b0;
      pack_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lvl_q      <= '0;
    end else if (seed_start) begin
      seed_q     <= seed_val;
      beat_v_q   <= 1'b0;
      pack_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lvl_q      <= '0;
    end else begin
      unique case (state_q)
        SEED_INIT: begin
          a_q       <= seed_q ^ (seed_q >> 30);
          acc_q     <= '0;
          mul_cnt_q <= 5'd31;
          i_q       <= 3'd1;
        end
        SEED_MUL: begin
          acc_q <= (acc_q << 1) +
                   (MULT[mul_cnt_q] ? a_q : 32'd0);
          mul_cnt_q <= mul_cnt_q - 5'd1;
        end
        SEED_WR: begin
          s_q[i_q[1:0] - 2'd1] <= wr_x;
          a_q       <= wr_x ^ (wr_x >> 30);
          acc_q     <= '0;
          mul_cnt_q <= 5'd31;
          i_q       <= i_q + 3'd1;
          if (i_q == 3'd4 && s_q[0] == '0 &&
              s_q[1] == '0 && s_q[2] == '0 &&
              wr_x == '0) begin
            s_q[0] <= 32'd1;
          end
        end
        RUN: begin
          if (adv) begin
            for (int k = 0; k < 4; k++) s_q[k] <= sn[k];
            if (last) begin
              beat_q     <= beat_w;
              pack_cnt_q <= '0;
            end else begin
              pack_q     <= beat_w;
              pack_cnt_q <= pack_cnt_q + PW'(1);
            end
          end
        end
        default: ;
      endcase

      if (adv && last) beat_v_q <= 1'b1;
      else if (push)   beat_v_q <= 1'b0;

      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

endmodule

// File: tb/tb_prng_xoshiro_axis.sv
// Bench: two instances (1 and 4 words per beat) checked
// against a behavioural xoshiro128** / MT-seed model.
module tb_prng_xoshiro_axis;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_start = 1'b0;
  logic [31:0] seed_val = '0;
  logic        busy1, busy4;
  logic [2:0]  lvl1, lvl4;

  always #5 clk = ~clk;

  prng_xoshiro_axis_if #(.W(32))  if1();
  prng_xoshiro_axis_if #(.W(128)) if4();

  prng_xoshiro_axis #(
    .OUT_WORDS(1), .FIFO_DEPTH(4)
  ) u1 (
    .clk(clk), .rst(rst), .output_axis(if1),
    .busy(busy1), .fifo_level(lvl1),
    .seed_val(seed_val), .seed_start(seed_start)
  );

  prng_xoshiro_axis #(
    .OUT_WORDS(4), .FIFO_DEPTH(4)
  ) u4 (
    .clk(clk), .rst(rst), .output_axis(if4),
    .busy(busy4), .fifo_level(lvl4),
    .seed_val(seed_val), .seed_start(seed_start)
  );

  typedef struct {
    logic [31:0]  seed;
    logic [127:0] st;
    int           n;
    int           rmode;
  } vec_t;

  localparam logic [127:0] DEF_ST = {
    32'd1875628136, 32'd2950281878,
    32'd2938499221, 32'd1301868182
  };

  int checks = 0;
  int errors = 0;
  int hsw1, hsw4;
  logic [127:0] m1, m4;
  vec_t vecs [4];

  function automatic logic [31:0] rotl(
    input logic [31:0] x, input int k
  );
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] xo_out(
    input logic [127:0] s
  );
    logic [31:0] s1;
    s1 = s[63:32];
    return rotl(s1 * 32'd5, 7) * 32'd9;
  endfunction

  function automatic logic [127:0] xo_next(
    input logic [127:0] s
  );
    logic [31:0] s0, s1, s2, s3, t;
    s0 = s[31:0];  s1 = s[63:32];
    s2 = s[95:64]; s3 = s[127:96];
    t  = s1 << 9;
    s2 = s2 ^ s0;
    s3 = s3 ^ s1;
    s1 = s1 ^ s2;
    s0 = s0 ^ s3;
    s2 = s2 ^ t;
    s3 = rotl(s3, 11);
    return {s3, s2, s1, s0};
  endfunction

  function automatic logic [127:0] expand(
    input logic [31:0] seed
  );
    logic [127:0] r;
    logic [31:0]  x;
    r = '0;
    x = seed;
    for (int i = 1; i <= 4; i++) begin
      x = 32'd1812433253 * (x ^ (x >> 30)) + 32'(i);
      r[32*(i-1) +: 32] = x;
    end
    if (r == '0) r[0] = 1'b1;
    return r;
  endfunction

  task automatic chk(
    input string name,
    input logic [159:0] act,
    input logic [159:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tvalid1"}, 160'(if1.tvalid), 0);
    chk({tag, "_tvalid4"}, 160'(if4.tvalid), 0);
    chk({tag, "_lvl1"}, 160'(lvl1), 0);
    chk({tag, "_lvl4"}, 160'(lvl4), 0);
    chk({tag, "_tdata1"}, 160'(if1.tdata), 0);
    chk({tag, "_tdata4"}, 160'(if4.tdata), 0);
  endtask

  task automatic count_busy(input string tag);
    int c1, c4;
    c1 = 0;
    c4 = 0;
    for (int k = 0; k < 400; k++) begin
      if (!busy1 && !busy4) break;
      if (busy1) c1++;
      if (busy4) c4++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_busy1"}, 160'(c1), 133);
    chk({tag, "_busy4"}, 160'(c4), 133);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    seed_start = 1'b0;
    if1.tready = 1'b0;
    if4.tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk({tag, "_rbusy1"}, 160'(busy1), 0);
    chk({tag, "_rbusy4"}, 160'(busy4), 0);
    chk_idle({tag, "_rst"});
    rst = 1'b0;
    #1;
    count_busy(tag);
  endtask

  task automatic do_seed(
    input string tag, input logic [31:0] sv
  );
    @(negedge clk);
    seed_val = sv;
    seed_start = 1'b1;
    @(negedge clk);
    seed_start = 1'b0;
    #1;
    chk_idle({tag, "_flush"});
    count_busy(tag);
  endtask

  task automatic stream(
    input string tag, input int n1, input int n4,
    input int rmode, input bit chk_full
  );
    int got1, got4, cyc;
    logic pv1, pr1, pv4, pr4, r1, r4;
    logic [31:0]  pd1;
    logic [127:0] pd4, e4;
    got1 = 0; got4 = 0; cyc = 0;
    pv1 = 0; pr1 = 0; pv4 = 0; pr4 = 0;
    pd1 = '0; pd4 = '0;
    hsw1 = 0; hsw4 = 0;
    while ((got1 < n1 || got4 < n4) && cyc < 20000) begin
      @(negedge clk);
      if (pv1 && !pr1) begin
        chk({tag, "_hold_v1"}, 160'(if1.tvalid), 1);
        chk({tag, "_hold_d1"}, 160'(if1.tdata),
            160'(pd1));
      end
      if (pv4 && !pr4) begin
        chk({tag, "_hold_v4"}, 160'(if4.tvalid), 1);
        chk({tag, "_hold_d4"}, 160'(if4.tdata),
            160'(pd4));
      end
      if (chk_full && cyc == 1) begin
        chk({tag, "_fullpop1"}, 160'(lvl1), 4);
        chk({tag, "_fullpop4"}, 160'(lvl4), 4);
      end
      r1 = (got1 < n1) &&
           (rmode == 0 || $urandom_range(1, 0) == 1);
      r4 = (got4 < n4) &&
           (rmode == 0 || $urandom_range(1, 0) == 1);
      if1.tready = r1;
      if4.tready = r4;
      if (if1.tvalid && r1) begin
        chk({tag, "_beat1"}, 160'(if1.tdata),
            160'(xo_out(m1)));
        m1 = xo_next(m1);
        got1++;
        if (cyc >= 40 && cyc < 80) hsw1++;
      end
      if (if4.tvalid && r4) begin
        e4 = '0;
        for (int k = 0; k < 4; k++) begin
          e4[32*k +: 32] = xo_out(m4);
          m4 = xo_next(m4);
        end
        chk({tag, "_beat4"}, 160'(if4.tdata),
            160'(e4));
        got4++;
        if (cyc >= 40 && cyc < 80) hsw4++;
      end
      pv1 = if1.tvalid; pr1 = r1; pd1 = if1.tdata;
      pv4 = if4.tvalid; pr4 = r4; pd4 = if4.tdata;
      cyc++;
    end
    if (cyc >= 20000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d/%0d beats",
               tag, got1, got4);
    end
    @(posedge clk);
    #1;
    if1.tready = 1'b0;
    if4.tready = 1'b0;
  endtask

  initial begin
    int lat1, lat4;
    vecs[0] = '{32'd5489, DEF_ST, 200, 1};
    vecs[1] = '{32'h12345678, expand(32'h12345678),
                200, 0};
    vecs[2] = '{32'h0, expand(32'h0), 64, 1};
    vecs[3] = '{32'hdeadbeef, expand(32'hdeadbeef),
                64, 1};
    if1.tready = 1'b0;
    if4.tready = 1'b0;

    do_reset("por");
    m1 = DEF_ST;
    m4 = DEF_ST;
    lat1 = -1;
    lat4 = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      if (if1.tvalid && lat1 < 0) lat1 = k;
      if (if4.tvalid && lat4 < 0) lat4 = k;
    end
    chk("lat1", 160'(lat1), 2);
    chk("lat4", 160'(lat4), 5);
    stream("def", 1000, 250, 0, 1'b0);

    for (int v = 0; v < 4; v++) begin
      do_seed($sformatf("vec%0d", v), vecs[v].seed);
      m1 = vecs[v].st;
      m4 = vecs[v].st;
      stream($sformatf("vec%0d", v), vecs[v].n,
             vecs[v].n / 4, vecs[v].rmode, 1'b0);
    end

    do_seed("stall", 32'hcafef00d);
    m1 = expand(32'hcafef00d);
    m4 = m1;
    repeat (80) @(negedge clk);
    chk("stall_lvl1", 160'(lvl1), 4);
    chk("stall_lvl4", 160'(lvl4), 4);
    repeat (20) @(negedge clk);
    chk("stall_hold1", 160'(lvl1), 4);
    chk("stall_hold4", 160'(lvl4), 4);
    stream("stall", 200, 50, 0, 1'b1);
    chk("tput1", 160'(hsw1), 40);
    chk("tput4", 160'(hsw4), 10);

    @(negedge clk);
    seed_val = 32'h0badf00d;
    seed_start = 1'b1;
    @(negedge clk);
    seed_start = 1'b0;
    repeat (58) @(negedge clk);
    do_reset("rst_seed");
    m1 = DEF_ST;
    m4 = DEF_ST;
    stream("rst_seed", 32, 8, 1, 1'b0);

    do_reset("rst_run");
    m1 = DEF_ST;
    m4 = DEF_ST;
    stream("rst_run", 32, 8, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
